score_sequencer: RTL and testbench

Reads a packed multi-track score from an on-chip ROM and drives the four 6-bit note codes `track0`..`track3` consumed by the song driver. Steps through score entries on the 16 Hz beat tick, holding each chord for its encoded duration. Provides play/pause, song selection and end-of-song signalling. Sits directly upstream of the song driver in the same `EGO1_Clock` domain.

---
 rtl/score_pkg.sv | 27 ++
 rtl/score_sequencer_if.sv | 19 +
 rtl/score_rom.sv | 9 +
 rtl/score_sequencer.sv | 95 +++++++++
 tb/tb_score_sequencer.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// score_pkg: score entry layout, song base addresses, FSM states and the score ROM contents
// Entry layout: {end[28], dur[27:24], n3[23:18], n2[17:12], n1[11:6], n0[5:0]}
package score_pkg;
    localparam int ENTRY_W = 29;
    localparam int NOTE_W  = 6;
    localparam int DUR_W   = 4;
    localparam int DUR_LSB = 24;
    localparam int END_BIT = 28;
    localparam logic [NOTE_W-1:0] NOTE_REST = '0;
    localparam logic [7:0] SONG_BASE [4] = '{8'h00, 8'h10, 8'h20, 8'h30};
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_HOLD, S_DONE} state_t;
    // Score image; every address outside a song reads as a terminator so a
    // runaway position always stops cleanly.
    function automatic logic [ENTRY_W-1:0] rom_entry(input int addr);
        case (addr)
            'h00: rom_entry = {1'b0, 4'd2, 6'd8,  6'd7,  6'd6,  6'd5};
            'h01: rom_entry = {1'b0, 4'd0, 6'd4,  6'd3,  6'd2,  6'd1};
            'h10: rom_entry = {1'b0, 4'd1, 6'd34, 6'd33, 6'd32, 6'd31};
            'h11: rom_entry = {1'b0, 4'd1, 6'd38, 6'd37, 6'd36, 6'd35};
            'h12: rom_entry = {1'b0, 4'd3, 6'd44, 6'd43, 6'd42, 6'd41};
            'h20: rom_entry = {1'b0, 4'd7, 6'd13, 6'd12, 6'd11, 6'd10};
            'h21: rom_entry = {1'b0, 4'd0, 6'd23, 6'd22, 6'd21, 6'd20};
            'h30: rom_entry = {1'b0, 4'd0, 6'd53, 6'd52, 6'd51, 6'd50};
            default: rom_entry = {1'b1, 28'd0};
        endcase
    endfunction
endpackage

// File: rtl/score_sequencer_if.sv
// score_sequencer_if: control inputs and note outputs of the score sequencer
// master: sequencer side (beat_tick/play/song_sel in; track0..3/playing/song_done/position out)
// slave:  song driver / controller side (directions mirrored)
interface score_sequencer_if import score_pkg::*; #(parameter int ADDR_W = 8);
    logic              beat_tick;
    logic              play;
    logic [1:0]        song_sel;
    logic [NOTE_W-1:0] track0;
    logic [NOTE_W-1:0] track1;
    logic [NOTE_W-1:0] track2;
    logic [NOTE_W-1:0] track3;
    logic              playing;
    logic              song_done;
    logic [ADDR_W-1:0] position;
    modport master(input beat_tick, play, song_sel,
                   output track0, track1, track2, track3, playing, song_done, position);
    modport slave(output beat_tick, play, song_sel,
                  input track0, track1, track2, track3, playing, song_done, position);
endinterface

// File: rtl/score_rom.sv
// score_rom: synchronous-read score ROM
// Ports: i_clk clock, i_addr entry address, o_data entry registered one cycle after i_addr
module score_rom import score_pkg::*; #(parameter int ADDR_W = 8) (
    input  logic               i_clk,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_data
);
    always_ff @(posedge i_clk) o_data <= rom_entry(int'(i_addr));
endmodule

// File: rtl/score_sequencer.sv
// score_sequencer: steps a packed four-track score from ROM on the beat tick
// Ports: EGO1_Clock clock, reset sync active-high, bus (score_sequencer_if.master)
// Build option: SCORE_LOOP_EN restarts the latched song at its terminator instead of stopping.
module score_sequencer import score_pkg::*; #(
    parameter int ADDR_W   = 8,
    parameter int SONG_CNT = 4
) (
    input logic                 EGO1_Clock,
    input logic                 reset,
    score_sequencer_if.master   bus
);
    state_t             r_state, w_next;
    logic [ADDR_W-1:0]  r_pos;
    logic [DUR_W-1:0]   r_dur;
    logic [NOTE_W-1:0]  r_note [4];
    logic               r_playing, r_done;
    logic [ENTRY_W-1:0] w_entry;
    logic [1:0]         w_sel;
    logic               w_end, w_step, w_mute;

    score_rom #(.ADDR_W(ADDR_W)) u_rom (.i_clk(EGO1_Clock), .i_addr(r_pos), .o_data(w_entry));

    assign w_sel  = (int'(bus.song_sel) < SONG_CNT) ? bus.song_sel : 2'd0;
    assign w_end  = w_entry[END_BIT];
    // The tick that expires the last beat of a chord moves on to the next entry.
    assign w_step = bus.play && bus.beat_tick && (r_dur == '0);
    assign w_mute = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_HOLD && !bus.play);

`ifdef SCORE_LOOP_EN
    localparam state_t END_NEXT = S_FETCH;
    logic [1:0] r_song;
    always_ff @(posedge EGO1_Clock)
        r_song <= reset ? 2'd0 : (r_state == S_IDLE && bus.play) ? w_sel : r_song;
`else
    localparam state_t END_NEXT = S_DONE;
`endif

    always_ff @(posedge EGO1_Clock) r_state <= reset ? S_IDLE : w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.play ? S_FETCH : S_IDLE;
            S_FETCH: w_next = S_LOAD;
            S_LOAD:  w_next = w_end ? END_NEXT : S_HOLD;
            S_HOLD:  w_next = w_step ? S_FETCH : S_HOLD;
            S_DONE:  w_next = bus.play ? S_DONE : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge EGO1_Clock) begin
        if (reset) begin
            r_pos     <= '0;
            r_dur     <= '0;
            r_note    <= '{default: NOTE_REST};
            r_playing <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_playing <= (r_state == S_HOLD) && bus.play;
            r_done    <= (r_state == S_LOAD) && w_end;
            case (r_state)
                S_IDLE: begin
                    // Cleared here so the start-up FETCH/LOAD gap stays silent.
                    r_note <= '{default: NOTE_REST};
                    if (bus.play) r_pos <= ADDR_W'(SONG_BASE[w_sel]);
                end
                S_LOAD: begin
                    if (!w_end) begin
                        r_dur  <= w_entry[DUR_LSB +: DUR_W];
                        r_note <= '{w_entry[5:0], w_entry[11:6], w_entry[17:12], w_entry[23:18]};
                    end
`ifdef SCORE_LOOP_EN
                    if (w_end) r_pos <= ADDR_W'(SONG_BASE[r_song]);
`endif
                end
                S_HOLD: begin
                    if (bus.play && bus.beat_tick) begin
                        if (r_dur == '0) r_pos <= r_pos + ADDR_W'(1);
                        else r_dur <= r_dur - 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.track0    = w_mute ? NOTE_REST : r_note[0];
    assign bus.track1    = w_mute ? NOTE_REST : r_note[1];
    assign bus.track2    = w_mute ? NOTE_REST : r_note[2];
    assign bus.track3    = w_mute ? NOTE_REST : r_note[3];
    assign bus.playing   = r_playing;
    assign bus.song_done = r_done;
    assign bus.position  = r_pos;
endmodule

// File: tb/tb_score_sequencer.sv
// tb_score_sequencer: scoreboard bench for score_sequencer
module tb_score_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    score_sequencer_if #(.ADDR_W(8)) bus();
    score_sequencer #(.ADDR_W(8), .SONG_CNT(4)) dut (.EGO1_Clock(clk), .reset(rst), .bus(bus));

    typedef struct packed {logic [7:0] pos; logic [23:0] chord;} exp_t;
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int done_wide = 0;
    logic prev_done = 1'b0;
    wire [23:0] w_chord = {bus.track3, bus.track2, bus.track1, bus.track0};

    always @(negedge clk) begin
        if (bus.song_done === 1'b1 && prev_done === 1'b1) done_wide++;
        if (bus.song_done === 1'b1) done_cnt++;
        prev_done = bus.song_done;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "timeout");
    end

    function automatic logic [23:0] ch(input int a, input int b, input int c, input int d);
        return {6'(d), 6'(c), 6'(b), 6'(a)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tick();
        bus.beat_tick = 1'b1;
        @(negedge clk);
        bus.beat_tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.play = 1'b0;
        bus.beat_tick = 1'b0;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        n_checks += 4;
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL reset_tracks: got %h expected 0", w_chord); end
        if (bus.position !== 8'h00) begin n_fail++; $display("FAIL reset_position: got %h expected 00", bus.position); end
        if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL reset_playing: got %b expected 0", bus.playing); end
        if (bus.song_done !== 1'b0) begin n_fail++; $display("FAIL reset_song_done: got %b expected 0", bus.song_done); end
    endtask

    task automatic test_play();
        exp_t e;
        cyc(1);
        tick();
        tick();
        n_checks++;
        if (bus.position !== 8'h00) begin n_fail++; $display("FAIL idle_tick_position: got %h expected 00", bus.position); end
        bus.song_sel = 2'd0;
        bus.play = 1'b1;
        exp_q.push_back(exp_t'{pos: 8'h00, chord: ch(5, 6, 7, 8)});
        cyc(2);
        n_checks++;
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL start_gap_silent: got %h expected 0", w_chord); end
        cyc(1);
        e = exp_q.pop_front();
        n_checks += 3;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL first_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL first_position: got %h expected %h", bus.position, e.pos); end
        if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL playing_lag: got %b expected 0", bus.playing); end
        tick();
        cyc(1);
        tick();
        n_checks += 2;
        if (bus.position !== 8'h00) begin n_fail++; $display("FAIL early_advance: got %h expected 00", bus.position); end
        if (bus.playing !== 1'b1) begin n_fail++; $display("FAIL playing_hold: got %b expected 1", bus.playing); end
        tick();
        n_checks += 2;
        if (bus.position !== 8'h01) begin n_fail++; $display("FAIL third_tick_advance: got %h expected 01", bus.position); end
        if (w_chord !== ch(5, 6, 7, 8)) begin n_fail++; $display("FAIL gap_hold_chord: got %h expected %h", w_chord, ch(5, 6, 7, 8)); end
        exp_q.push_back(exp_t'{pos: 8'h01, chord: ch(1, 2, 3, 4)});
        tick();
        tick();
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL second_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL gap_tick_position: got %h expected %h", bus.position, e.pos); end
    endtask

`ifdef SCORE_LOOP_EN
    task automatic test_loop();
        exp_t e;
        int d0;
        cyc(3);
        n_checks++;
        if (bus.position !== 8'h01) begin n_fail++; $display("FAIL no_accumulate: got %h expected 01", bus.position); end
        d0 = done_cnt;
        tick();
        cyc(2);
        n_checks += 3;
        if (bus.song_done !== 1'b1) begin n_fail++; $display("FAIL loop_done_pulse: got %b expected 1", bus.song_done); end
        if (bus.position !== 8'h00) begin n_fail++; $display("FAIL loop_reload: got %h expected 00", bus.position); end
        if (w_chord !== ch(1, 2, 3, 4)) begin n_fail++; $display("FAIL loop_gap_hold: got %h expected %h", w_chord, ch(1, 2, 3, 4)); end
        exp_q.push_back(exp_t'{pos: 8'h00, chord: ch(5, 6, 7, 8)});
        cyc(2);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL loop_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL loop_position: got %h expected %h", bus.position, e.pos); end
        cyc(2);
        n_checks += 2;
        if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL loop_done_count: got %0d expected %0d", done_cnt, d0 + 1); end
        if (done_wide !== 0) begin n_fail++; $display("FAIL loop_done_width: got %0d expected 0", done_wide); end
        do_reset();
    endtask
`else
    task automatic test_done();
        int d0;
        cyc(3);
        n_checks++;
        if (bus.position !== 8'h01) begin n_fail++; $display("FAIL no_accumulate: got %h expected 01", bus.position); end
        d0 = done_cnt;
        tick();
        cyc(2);
        n_checks += 2;
        if (bus.song_done !== 1'b1) begin n_fail++; $display("FAIL done_pulse: got %b expected 1", bus.song_done); end
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL done_tracks: got %h expected 0", w_chord); end
        tick();
        tick();
        cyc(2);
        n_checks += 5;
        if (bus.position !== 8'h02) begin n_fail++; $display("FAIL done_position: got %h expected 02", bus.position); end
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL done_stays_silent: got %h expected 0", w_chord); end
        if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL done_playing: got %b expected 0", bus.playing); end
        if (done_cnt !== d0 + 1) begin n_fail++; $display("FAIL done_count: got %0d expected %0d", done_cnt, d0 + 1); end
        if (done_wide !== 0) begin n_fail++; $display("FAIL done_width: got %0d expected 0", done_wide); end
        bus.play = 1'b0;
        cyc(2);
    endtask
`endif

    task automatic test_pause();
        exp_t e;
        bus.song_sel = 2'd2;
        bus.play = 1'b1;
        exp_q.push_back(exp_t'{pos: 8'h20, chord: ch(10, 11, 12, 13)});
        cyc(3);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL pause_song_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL pause_song_position: got %h expected %h", bus.position, e.pos); end
        tick();
        tick();
        bus.play = 1'b0;
        bus.beat_tick = 1'b1;
        @(negedge clk);
        bus.beat_tick = 1'b0;
        n_checks += 2;
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL pause_silence: got %h expected 0", w_chord); end
        if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL pause_playing: got %b expected 0", bus.playing); end
        repeat (10) tick();
        n_checks += 2;
        if (bus.position !== 8'h20) begin n_fail++; $display("FAIL pause_frozen: got %h expected 20", bus.position); end
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL pause_still_silent: got %h expected 0", w_chord); end
        bus.play = 1'b1;
        cyc(1);
        n_checks += 2;
        if (w_chord !== ch(10, 11, 12, 13)) begin n_fail++; $display("FAIL resume_chord: got %h expected %h", w_chord, ch(10, 11, 12, 13)); end
        if (bus.playing !== 1'b1) begin n_fail++; $display("FAIL resume_playing: got %b expected 1", bus.playing); end
        repeat (5) tick();
        n_checks++;
        if (bus.position !== 8'h20) begin n_fail++; $display("FAIL resume_early: got %h expected 20", bus.position); end
        tick();
        n_checks++;
        if (bus.position !== 8'h21) begin n_fail++; $display("FAIL resume_sixth_tick: got %h expected 21", bus.position); end
        exp_q.push_back(exp_t'{pos: 8'h21, chord: ch(20, 21, 22, 23)});
        cyc(2);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL pause_next_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL pause_next_position: got %h expected %h", bus.position, e.pos); end
        do_reset();
    endtask

    task automatic test_sel_reset();
        exp_t e;
        int d0;
        bus.song_sel = 2'd1;
        bus.play = 1'b1;
        exp_q.push_back(exp_t'{pos: 8'h10, chord: ch(31, 32, 33, 34)});
        cyc(3);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL song1_chord0: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL song1_pos0: got %h expected %h", bus.position, e.pos); end
        bus.song_sel = 2'd2;
        tick();
        tick();
        exp_q.push_back(exp_t'{pos: 8'h11, chord: ch(35, 36, 37, 38)});
        cyc(2);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL sel_ignored_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL sel_ignored_pos: got %h expected %h", bus.position, e.pos); end
        tick();
        tick();
        exp_q.push_back(exp_t'{pos: 8'h12, chord: ch(41, 42, 43, 44)});
        cyc(2);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL song1_chord2: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL song1_pos2: got %h expected %h", bus.position, e.pos); end
        d0 = done_cnt;
        rst = 1'b1;
        cyc(1);
        n_checks += 4;
        if (w_chord !== 24'h0) begin n_fail++; $display("FAIL midreset_tracks: got %h expected 0", w_chord); end
        if (bus.position !== 8'h00) begin n_fail++; $display("FAIL midreset_position: got %h expected 00", bus.position); end
        if (bus.playing !== 1'b0) begin n_fail++; $display("FAIL midreset_playing: got %b expected 0", bus.playing); end
        if (bus.song_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done: got %b expected 0", bus.song_done); end
        bus.play = 1'b0;
        rst = 1'b0;
        cyc(2);
        n_checks++;
        if (done_cnt !== d0) begin n_fail++; $display("FAIL midreset_no_pulse: got %0d expected %0d", done_cnt, d0); end
        bus.play = 1'b1;
        exp_q.push_back(exp_t'{pos: 8'h20, chord: ch(10, 11, 12, 13)});
        cyc(3);
        e = exp_q.pop_front();
        n_checks += 2;
        if (w_chord !== e.chord) begin n_fail++; $display("FAIL restart_song2_chord: got %h expected %h", w_chord, e.chord); end
        if (bus.position !== e.pos) begin n_fail++; $display("FAIL restart_song2_pos: got %h expected %h", bus.position, e.pos); end
        bus.play = 1'b0;
        cyc(2);
    endtask

    initial begin
        bus.play = 1'b0;
        bus.beat_tick = 1'b0;
        bus.song_sel = 2'd0;
        test_reset();
        test_play();
`ifdef SCORE_LOOP_EN
        test_loop();
`else
        test_done();
`endif
        test_pause();
        test_sel_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
